// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory behind a valid/ready request
// channel. It responds after a fixed number of wait states and supports
// per-byte writes. Misaligned or out-of-range requests return an error
// and leave the array untouched.
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    // The counter keeps at least one bit, so a zero-wait build still has a legal width.
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_wstrb;
    logic          cap_we;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          wait_done;
    logic          enter_resp;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic [3:0]    op_wstrb;
    logic          op_we;
    logic          op_err;
    logic [AW-1:0] op_idx;
    logic          mem_we;

    assign accept    = (state == IDLE) && req_valid;
    assign wait_done = (state == WAIT) && (wait_cnt == CNT_LAST);
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || wait_done;

    // A zero-wait build enters RESP on the acceptance edge, before anything
    // has been captured, so the operation then comes straight from the inputs.
    assign op_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign op_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign op_wstrb = (state == IDLE) ? req_wstrb : cap_wstrb;
    assign op_we    = (state == IDLE) ? req_we    : cap_we;

    assign op_err = (op_addr[1:0] != 2'b00) || ({2'b00, op_addr[31:2]} >= 32'(DEPTH));
    assign op_idx = op_addr[AW+1:2];
    assign mem_we = enter_resp && op_we && !op_err && !rst;

    // Control FSM. It captures the request, counts wait states and holds the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            cap_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_wstrb <= req_wstrb;
                        cap_we    <= req_we;
                        wait_cnt  <= '0;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= op_err;
                            rsp_rdata <= (op_err || op_we) ? 32'h0 : mem[op_idx];
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= op_err;
                        rsp_rdata <= (op_err || op_we) ? 32'h0 : mem[op_idx];
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-masked array write on the edge entering RESP. The array is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (op_wstrb[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. Instance a is built with 2 wait states
// and instance b with none. Drivers push expected responses into queues,
// and one monitor per instance pops and compares them on each handshake.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_we, a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_ready;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_wstrb;
    logic        b_req_valid, b_req_we, b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_ready;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_wstrb;

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_we(a_req_we), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb), .req_ready(a_req_ready),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .rsp_ready(a_rsp_ready)
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_we(b_req_we), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .rsp_ready(b_rsp_ready)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s", name);
    endtask

    // Monitor for instance a: response latency on first valid, data/err on handshake.
    logic a_hold = 1'b0;
    always @(negedge clk) begin
        if (rst) a_hold <= 1'b0;
        else begin
            if (a_rsp_valid && !a_hold) begin
                if (qa.size() == 0) fail_now("a_unexpected_response");
                else chk("a_latency", 32'(cyc - qa[0].acc), 32'd3);
            end
            if (a_rsp_valid && a_rsp_ready && qa.size() > 0) begin
                chk("a_rdata", a_rsp_rdata, qa[0].rdata);
                chk("a_err", {31'b0, a_rsp_err}, {31'b0, qa[0].err});
                void'(qa.pop_front());
            end
            a_hold <= a_rsp_valid && !a_rsp_ready;
        end
    end

    // Monitor for instance b: the zero-wait build answers one cycle after acceptance.
    logic b_hold = 1'b0;
    always @(negedge clk) begin
        if (rst) b_hold <= 1'b0;
        else begin
            if (b_rsp_valid && !b_hold) begin
                if (qb.size() == 0) fail_now("b_unexpected_response");
                else chk("b_latency", 32'(cyc - qb[0].acc), 32'd1);
            end
            if (b_rsp_valid && b_rsp_ready && qb.size() > 0) begin
                chk("b_rdata", b_rsp_rdata, qb[0].rdata);
                chk("b_err", {31'b0, b_rsp_err}, {31'b0, qb[0].err});
                void'(qb.pop_front());
            end
            b_hold <= b_rsp_valid && !b_rsp_ready;
        end
    end

    // Presents one request, waits for acceptance and queues its expected response.
    task automatic issue(input int inst, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] erd, input logic eerr, output int acc);
        exp_t e;
        int   n;
        logic rdy;
        acc = -1;
        if (inst == 0) begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
            a_req_wdata = wdata; a_req_wstrb = strb;
        end else begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
            b_req_wdata = wdata; b_req_wstrb = strb;
        end
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = (inst == 0) ? a_req_ready : b_req_ready;
            n++;
        end
        if (!rdy) begin
            fail_now("accept_timeout");
        end else begin
            e.rdata = erd; e.err = eerr; e.acc = cyc;
            acc = cyc;
            if (inst == 0) qa.push_back(e); else qb.push_back(e);
        end
        @(posedge clk);
        #1;
        // Scramble the inputs once accepted; the responder must use its captured copy.
        if (inst == 0) begin
            a_req_valid = 1'b0; a_req_addr = 32'hFFFF_FFF1; a_req_wdata = 32'h5A5A_5A5A; a_req_wstrb = 4'hF;
        end else begin
            b_req_valid = 1'b0; b_req_addr = 32'hFFFF_FFF1; b_req_wdata = 32'h5A5A_5A5A; b_req_wstrb = 4'hF;
        end
    endtask

    // Waits until every queued response for an instance has been consumed.
    task automatic drain(input int inst);
        int n = 0;
        while (((inst == 0) ? qa.size() : qb.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (((inst == 0) ? qa.size() : qb.size()) != 0) fail_now("response_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int inst, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] erd, input logic eerr);
        int acc;
        issue(inst, we, addr, wdata, strb, erd, eerr, acc);
        drain(inst);
    endtask

    initial begin
        int acc0, acc1, acc2, n;
        rst = 1'b1;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_wstrb = 0; a_rsp_ready = 1;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wstrb = 0; b_rsp_ready = 1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, a_rsp_err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'b0, a_req_ready}, 32'd1);
        @(posedge clk); #1;

        // Full write, then read back
        txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);
        // Partial write of bytes 0 and 2
        txn(0, 1, 32'h10, 32'h11223344, 4'h5, 32'h0, 0);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 0);
        // Error cases: misaligned and out of range; array untouched
        txn(0, 0, 32'h13, 32'h0, 4'h0, 32'h0, 1);
        txn(0, 0, 32'h400, 32'h0, 4'h0, 32'h0, 1);
        txn(0, 1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
        txn(0, 1, 32'h410, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 0);
        // Zero-strobe write is a no-op that still responds
        txn(0, 1, 32'h10, 32'h0, 4'h0, 32'h0, 0);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 0);
        // Last in-range word
        txn(0, 1, 32'h3FC, 32'hAABBCCDD, 4'hF, 32'h0, 0);
        txn(0, 0, 32'h3FC, 32'h0, 4'h0, 32'hAABBCCDD, 0);

        // Backpressure: response held for 5 cycles
        a_rsp_ready = 1'b0;
        issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 0, acc0);
        n = 0;
        while (!a_rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (!a_rsp_valid) fail_now("bp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", a_rsp_rdata, 32'hDE22BE44);
            chk("bp_req_ready", {31'b0, a_req_ready}, 32'd0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1 a_rsp_ready = 1'b1;
        drain(0);
        @(negedge clk);
        chk("bp_idle_req_ready", {31'b0, a_req_ready}, 32'd1);
        chk("bp_idle_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        @(posedge clk); #1;

        // Reset during the WAIT state of a write discards it
        txn(0, 1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 0);
        issue(0, 1, 32'h20, 32'h12345678, 4'hF, 32'h0, 0, acc0);
        #2 rst = 1'b1;
        qa.delete();
        @(negedge clk);
        chk("mid_rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("after_rst_req_ready", {31'b0, a_req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        txn(0, 0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 0);

        // Zero-wait build: back-to-back requests accepted every 2 cycles
        issue(1, 1, 32'h8, 32'h01020304, 4'hF, 32'h0, 0, acc0);
        issue(1, 0, 32'h8, 32'h0, 4'h0, 32'h01020304, 0, acc1);
        issue(1, 0, 32'h400, 32'h0, 4'h0, 32'h0, 1, acc2);
        drain(1);
        chk("b2b_gap_1", 32'(acc1 - acc0), 32'd2);
        chk("b2b_gap_2", 32'(acc2 - acc1), 32'd2);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
